// File: rtl/frame_decommutator.sv
// Frame decommutator: parses {F,ch}/len/payload byte frames into wide output frames.
// Optional saturating error counter enabled by defining FRAME_DECOMM_ERRCNT_EN.
module frame_decommutator #(
   parameter int NUM_CH  = 3,
   parameter int MAX_LEN = 9
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   out_valid,
   output logic [3:0]             out_channel,
   output logic [3:0]             out_len,
   output logic [8*MAX_LEN-1:0]   out_data,
   output logic                   frame_err,
   output logic [7:0]             err_count
);

   typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;

   localparam logic [3:0] NUM_CH_L  = 4'(NUM_CH);
   localparam logic [7:0] MAX_LEN_L = 8'(MAX_LEN);
   localparam int         W         = 8*MAX_LEN;

   state_t         state_q, state_d;
   logic [3:0]     ch_q, ch_d;
   logic [3:0]     len_q, len_d;
   logic [3:0]     idx_q, idx_d;
   logic [W-1:0]   asm_q, asm_d;
   logic           out_valid_q, out_valid_d;
   logic [3:0]     out_channel_q, out_channel_d;
   logic [3:0]     out_len_q, out_len_d;
   logic [W-1:0]   out_data_q, out_data_d;
   logic           frame_err_q, frame_err_d;

   always_comb begin
      state_d       = state_q;
      ch_d          = ch_q;
      len_d         = len_q;
      idx_d         = idx_q;
      asm_d         = asm_q;
      out_valid_d   = 1'b0;
      out_channel_d = out_channel_q;
      out_len_d     = out_len_q;
      out_data_d    = out_data_q;
      frame_err_d   = 1'b0;
      if (in_valid) begin
         case (state_q)
            HUNT: begin
               if (in_data[7:4] == 4'hF && (in_data[3:0] == 4'hF || in_data[3:0] < NUM_CH_L)) begin
                  ch_d    = in_data[3:0];
                  state_d = LEN;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            LEN: begin
               state_d = HUNT;
               if (ch_q == 4'hF) begin
                  if (in_data != 8'd0) frame_err_d = 1'b1;
               end else if (in_data == 8'd0) begin
                  out_valid_d   = 1'b1;
                  out_channel_d = ch_q;
                  out_len_d     = '0;
                  out_data_d    = '0;
               end else if (in_data > MAX_LEN_L) begin
                  frame_err_d = 1'b1;
               end else begin
                  len_d   = in_data[3:0];
                  asm_d   = '0;
                  idx_d   = '0;
                  state_d = PAYLOAD;
               end
            end
            PAYLOAD: begin
               for (int unsigned k = 0; k < MAX_LEN; k++) begin
                  if (idx_q == 4'(k)) asm_d[8*k +: 8] = in_data;
               end
               idx_d = idx_q + 4'd1;
               // The final byte is forwarded straight from asm_d so no extra cycle is spent.
               if (idx_q == len_q - 4'd1) begin
                  out_valid_d   = 1'b1;
                  out_channel_d = ch_q;
                  out_len_d     = len_q;
                  out_data_d    = asm_d;
                  idx_d         = '0;
                  state_d       = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state_q       <= HUNT;
         ch_q          <= '0;
         len_q         <= '0;
         idx_q         <= '0;
         asm_q         <= '0;
         out_valid_q   <= 1'b0;
         out_channel_q <= '0;
         out_len_q     <= '0;
         out_data_q    <= '0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         ch_q          <= ch_d;
         len_q         <= len_d;
         idx_q         <= idx_d;
         asm_q         <= asm_d;
         out_valid_q   <= out_valid_d;
         out_channel_q <= out_channel_d;
         out_len_q     <= out_len_d;
         out_data_q    <= out_data_d;
         frame_err_q   <= frame_err_d;
      end
   end

`ifdef FRAME_DECOMM_ERRCNT_EN
   logic [7:0] err_count_q, err_count_d;

   always_comb begin
      err_count_d = err_count_q;
      if (frame_err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (arst) err_count_q <= '0;
      else      err_count_q <= err_count_d;
   end

   assign err_count = err_count_q;
`else
   assign err_count = '0;
`endif

   assign out_valid   = out_valid_q;
   assign out_channel = out_channel_q;
   assign out_len     = out_len_q;
   assign out_data    = out_data_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_frame_decommutator.sv
// Directed self-checking bench for frame_decommutator (default parameters).
module tb_frame_decommutator;

   logic        clk = 1'b0;
   logic        arst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        out_valid;
   logic [3:0]  out_channel;
   logic [3:0]  out_len;
   logic [71:0] out_data;
   logic        frame_err;
   logic [7:0]  err_count;

   int total = 0;
   int bad   = 0;
   int n_valid = 0;
   int n_err   = 0;
   int n_both  = 0;

   frame_decommutator #(.NUM_CH(3), .MAX_LEN(9)) dut (
      .clk         (clk),
      .arst        (arst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_channel (out_channel),
      .out_len     (out_len),
      .out_data    (out_data),
      .frame_err   (frame_err),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle, then sample outputs just after the edge that consumed it.
   task automatic put(input logic [7:0] b, input logic v);
      @(negedge clk);
      in_valid = v;
      in_data  = b;
      @(posedge clk);
      #1;
      if (out_valid) n_valid++;
      if (frame_err) n_err++;
      if (out_valid && frame_err) n_both++;
   endtask

   task automatic clr_counts();
      n_valid = 0;
      n_err   = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      arst     = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_ch",    out_channel, 0);
      check("rst_len",   out_len, 0);
      check("rst_data",  out_data, 0);
      check("rst_err",   frame_err, 0);
      check("rst_cnt",   err_count, 0);
      @(negedge clk);
      arst = 1'b0;

      // Normal frame
      clr_counts();
      put(8'hF1, 1); put(8'h09, 1);
      for (int i = 1; i <= 8; i++) put(8'(i), 1);
      check("norm_early", n_valid, 0);
      put(8'h09, 1);
      check("norm_valid", out_valid, 1);
      check("norm_ch",    out_channel, 1);
      check("norm_len",   out_len, 9);
      check("norm_data",  out_data, 72'h090807060504030201);
      put(8'h00, 0);
      check("norm_pulse", out_valid, 0);
      check("norm_hold",  out_data, 72'h090807060504030201);

      // Idle frames then channel 0 frame
      clr_counts();
      for (int i = 0; i < 10; i++) begin put(8'hFF, 1); put(8'h00, 1); end
      check("idle_valid", n_valid, 0);
      check("idle_err",   n_err, 0);
      put(8'hF0, 1); put(8'h09, 1);
      for (int i = 0; i < 9; i++) put(8'hA0 + 8'(i), 1);
      check("idle_frame_cnt", n_valid, 1);
      check("idle_ch",   out_channel, 0);
      check("idle_data", out_data, 72'hA8A7A6A5A4A3A2A1A0);

      // Errors then a good frame
      clr_counts();
      put(8'h3A, 1);
      check("err_bad_hdr", frame_err, 1);
      put(8'hF5, 1);
      check("err_bad_ch", frame_err, 1);
      put(8'hF2, 1); put(8'h0C, 1);
      check("err_bad_len", frame_err, 1);
      put(8'hF2, 1); put(8'h09, 1);
      for (int i = 0; i < 9; i++) put(8'hB0 + 8'(i), 1);
      check("err_pulses", n_err, 3);
      check("err_frames", n_valid, 1);
      check("err_ch",     out_channel, 2);
      check("err_data",   out_data, 72'hB8B7B6B5B4B3B2B1B0);

      // Gaps and header-like payload bytes
      clr_counts();
      put(8'hF2, 1); put(8'h00, 0); put(8'h00, 0);
      put(8'h03, 1); put(8'h00, 0); put(8'h00, 0);
      put(8'hFF, 1); put(8'h00, 0); put(8'h00, 0);
      put(8'hF0, 1); put(8'h00, 0); put(8'h00, 0);
      check("gap_early", n_valid, 0);
      put(8'h11, 1);
      check("gap_valid", out_valid, 1);
      check("gap_len",   out_len, 3);
      check("gap_data",  out_data, 72'h11F0FF);
      check("gap_err",   n_err, 0);

      // Empty frame, then back-to-back frames
      clr_counts();
      put(8'hF1, 1); put(8'h00, 1);
      check("empty_valid", out_valid, 1);
      check("empty_len",   out_len, 0);
      check("empty_data",  out_data, 0);
      put(8'hF0, 1); put(8'h01, 1); put(8'h77, 1);
      check("b2b_data1", out_data, 72'h77);
      put(8'hF2, 1);
      check("b2b_gap", out_valid, 0);
      put(8'h01, 1); put(8'h88, 1);
      check("b2b_ch2",   out_channel, 2);
      check("b2b_data2", out_data, 72'h88);
      check("b2b_cnt",   n_valid, 3);

      // Reset mid-frame
      put(8'hF1, 1); put(8'h09, 1);
      for (int i = 1; i <= 4; i++) put(8'(i), 1);
      @(negedge clk);
      arst     = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("mrst_valid", out_valid, 0);
      check("mrst_ch",    out_channel, 0);
      check("mrst_data",  out_data, 0);
      @(negedge clk);
      arst = 1'b0;
      clr_counts();
      put(8'hF0, 1); put(8'h02, 1); put(8'h55, 1); put(8'h66, 1);
      check("mrst_frame", n_valid, 1);
      check("mrst_len",   out_len, 2);
      check("mrst_new",   out_data, 72'h6655);

      // Error counter saturation
      clr_counts();
      for (int i = 0; i < 300; i++) put(8'h00, 1);
      check("sat_pulses", n_err, 300);
`ifdef FRAME_DECOMM_ERRCNT_EN
      check("sat_cnt", err_count, 255);
      put(8'h00, 0);
      check("sat_hold", err_count, 255);
`else
      check("cnt_off", err_count, 0);
`endif
      check("never_both", n_both, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frame_decommutator.md
# frame_decommutator

Receive-side counterpart of the transmitter's channel commutator. Consumes the framed byte stream the commutator emits: header byte `{4'hF, channel}`, then a length byte, then `length` payload bytes. It parses each frame, assembles the payload into a wide register, and presents each completed frame with its channel number as a one-cycle pulse. Idle frames (channel `4'hF`, length 0) are absorbed silently. Malformed frames are flagged, and the parser resynchronises.

## Interface

Parameters:
- `NUM_CH`, 3: number of valid data channels; channel indices are `0..NUM_CH-1`.
- `MAX_LEN`, 9: maximum payload length in bytes; legal range 1..15.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `arst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  `in_data` carries a stream byte this cycle.
- `in_data`  input  8  stream byte.
- `out_valid`  output  1  one-cycle pulse: a complete frame is on `out_*`.
- `out_channel`  output  4  channel of the completed frame.
- `out_len`  output  4  payload length of the completed frame.
- `out_data`  output  8*MAX_LEN  payload; byte k is at `[8k+7:8k]`; unused bytes are 0.
- `frame_err`  output  1  one-cycle pulse on any framing error.
- `err_count`  output  8  saturating error count (see Configuration).

## Operation

- The FSM has three states: HUNT, LEN, PAYLOAD. State and counters update only on cycles with `in_valid`=1; when `in_valid`=0 everything holds.
- **HUNT**, on a byte:
  - If the upper nibble is F and the low nibble is F or < `NUM_CH`: latch the channel and go to LEN.
  - Otherwise: pulse `frame_err` and stay in HUNT.
- **LEN**, on byte L:
  - Channel F and L=0: idle frame; no output; go to HUNT.
  - Channel F and L≠0: error; go to HUNT.
  - Data channel and L=0: emit an empty frame (`out_valid`, `out_len`=0, `out_data`=0); go to HUNT.
  - Data channel and L>`MAX_LEN`: error; go to HUNT.
  - Otherwise: latch L, clear the assembly register and byte index, go to PAYLOAD.
- **PAYLOAD**: each byte is written at the current index, and the index increments. When byte L-1 is written:
  - Transfer the assembly register, channel, and L to the output registers.
  - Pulse `out_valid` and go to HUNT.
- Payload bytes are never interpreted as headers. An `0xFx` byte inside a payload is data.
- Output registers hold their last frame until the next completed frame overwrites them.
- Byte index and length counter are 4-bit; the index never exceeds `MAX_LEN-1`.

## Timing

- Reset values:
  - `out_valid`=0, `out_channel`=0, `out_len`=0, `out_data`=0.
  - `frame_err`=0, `err_count`=0.
  - State HUNT; assembly register and counters 0.
- Reset asserted mid-frame discards the partial frame. The cycle after reset is released, the block is in HUNT.
- Latency: `out_valid` rises in the cycle after the clock edge that samples the last payload byte. For an empty frame, it rises in the cycle after the length byte is sampled.
- `frame_err` rises in the cycle after the offending byte is sampled and lasts exactly one cycle.
- Throughput: one byte per cycle, with no back-pressure. Back-to-back frames are supported: a header sampled in the same cycle `out_valid` is high is parsed normally.
- `out_valid` and `frame_err` are never high in the same cycle.

## Configuration

- Macro: `FRAME_DECOMM_ERRCNT_EN`.
- Defined: `err_count` increments by 1 on every `frame_err` pulse, saturates at 255, and clears only on reset.
- Undefined: no counter logic; `err_count` is tied to 8'd0. `frame_err` behaviour is unchanged.

## Test plan

- **Normal frame.** Stream F1, 09, 01..09 with `in_valid`=1 continuously.
  - One cycle after byte 09 is sampled: `out_valid`=1 for one cycle, `out_channel`=1, `out_len`=9, `out_data`=72'h090807060504030201.
- **Idle frames.** Stream FF,00 repeated 10 times, then F0,09,A0..A8.
  - No `out_valid` during the idle bytes; a single frame follows on channel 0 with `out_data`=72'hA8A7…A0.
- **Errors.** Stream 3A, then F5 (channel ≥ `NUM_CH`), then F2,0C (length 12 > 9), then F2,09,…
  - Three `frame_err` pulses; the following F2 frame decodes correctly.
- **Gaps and payload header bytes.** Frame F2,03,FF,F0,11 with `in_valid` low for 2 cycles between every byte.
  - `out_data` low bytes = 11F0FF; `out_len`=3; single `out_valid` pulse.
- **Reset mid-frame.** Assert `arst` after byte 4 of a 9-byte payload.
  - All outputs 0; the next complete frame decodes with no stale bytes.
- **Error counter.** With `FRAME_DECOMM_ERRCNT_EN` defined, feed 300 bad headers.
  - `err_count`=255 and holds.
  - Without the macro, `err_count` stays 0.
